// File: rtl/sata_link_pkg.sv
// Shared SATA link-layer definitions: primitive dwords, decoded code indices,
// scrambler/CRC constants and the per-dword scrambler and CRC helpers.
package sata_link_pkg;

    localparam int CODES_COUNT = 13;

    localparam logic [3:0] CODE_DATA  = 4'd0;
    localparam logic [3:0] CODE_HOLD  = 4'd1;
    localparam logic [3:0] CODE_SYNC  = 4'd2;
    localparam logic [3:0] CODE_DMAT  = 4'd3;
    localparam logic [3:0] CODE_R_OK  = 4'd4;
    localparam logic [3:0] CODE_R_ERR = 4'd5;
    localparam logic [3:0] CODE_X_RDY = 4'd6;
    localparam logic [3:0] CODE_SOF   = 4'd7;
    localparam logic [3:0] CODE_EOF   = 4'd8;
    localparam logic [3:0] CODE_HOLDA = 4'd9;
    localparam logic [3:0] CODE_R_RDY = 4'd10;
    localparam logic [3:0] CODE_R_IP  = 4'd11;
    localparam logic [3:0] CODE_WTRM  = 4'd12;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] PRIM_X_RDY = 32'h5757B57C;
    localparam logic [31:0] PRIM_R_RDY = 32'h4A4A957C;
    localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] PRIM_R_IP  = 32'h5555B57C;
    localparam logic [31:0] PRIM_R_OK  = 32'h3535B57C;
    localparam logic [31:0] PRIM_R_ERR = 32'h5656B57C;
    localparam logic [31:0] PRIM_WTRM  = 32'h5858B57C;
    localparam logic [31:0] PRIM_DMAT  = 32'h3636B57C;

    localparam logic [15:0] SCR_SEED = 16'hF0F6;
    localparam logic [31:0] CRC_SEED = 32'h52325032;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    typedef enum logic [2:0] {
        KIND_DATA,
        KIND_PRIM,
        KIND_ALIGN,
        KIND_CONT,
        KIND_ERR
    } dword_kind_e;

    typedef enum logic {
        RX_IDLE,
        RX_FRAME
    } rx_state_e;

    typedef struct packed {
        rx_state_e state;
        logic      cont_active;
        logic      h0_valid;
        logic      h1_valid;
    } rx_dbg_t;

    // Fibonacci LFSR x^16+x^15+x^13+x^4+1; keystream bit i is s[15] before step i.
    function automatic logic [31:0] scr_keystream(input logic [15:0] state);
        logic [15:0] s;
        logic [31:0] ks;
        s  = state;
        ks = '0;
        for (int i = 0; i < 32; i++) begin
            ks[i] = s[15];
            s     = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
        end
        return ks;
    endfunction

    function automatic logic [15:0] scr_advance(input logic [15:0] state);
        logic [15:0] s;
        s = state;
        for (int i = 0; i < 32; i++) begin
            s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
        end
        return s;
    endfunction

    // MSB-first CRC-32 update over one dword, no reflection, no final xor.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    function automatic logic [CODES_COUNT-1:0] code_onehot(input logic [3:0] idx);
        logic [CODES_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/link_prim_decoder_if.sv
// Phy-rx input bundle and decoded output bundle of the link primitive decoder.
// master drives the phy side and observes results; slave is the decoder.
interface link_prim_decoder_if;

    logic                                  phy_ready;
    logic [31:0]                           phy_data;
    logic [3:0]                            phy_isk;
    logic                                  phy_err;
    logic                                  dword_val;
    logic [sata_link_pkg::CODES_COUNT-1:0] rcvd_dword;
    logic                                  dec_err;
    logic [31:0]                           data_out;
    logic                                  data_val_out;
    logic                                  data_last_out;
    logic                                  crc_good;
    logic                                  crc_bad;

    // No back-pressure: every qualified phy dword is consumed in its cycle,
    // and each result is valid for exactly the one cycle its strobe is high.
    modport master (
        output phy_ready, phy_data, phy_isk, phy_err,
        input  dword_val, rcvd_dword, dec_err, data_out, data_val_out,
        input  data_last_out, crc_good, crc_bad
    );

    modport slave (
        input  phy_ready, phy_data, phy_isk, phy_err,
        output dword_val, rcvd_dword, dec_err, data_out, data_val_out,
        output data_last_out, crc_good, crc_bad
    );

endinterface

// File: rtl/link_descrambler.sv
// 16-bit SATA scrambler LFSR producing one 32-bit keystream dword per advance.
// Shared by the receive descrambler and the transmit scrambler.
module link_descrambler
    import sata_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] keystream
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SCR_SEED;
        end else if (advance) begin
            lfsr_d = scr_advance(lfsr_q);
        end
    end

    assign keystream = scr_keystream(lfsr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SCR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/link_prim_decoder.sv
// SATA link receive front end: classifies phy dwords into one-hot primitive codes,
// drops ALIGN, expands CONT, descrambles frame payload and checks the frame CRC.
module link_prim_decoder #(
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int CODES_COUNT     = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    link_prim_decoder_if.slave     bus,
    output sata_link_pkg::rx_dbg_t dbg
);

    import sata_link_pkg::*;

    if (DATA_BYTE_WIDTH != 4) begin : g_bad_width
        $error("link_prim_decoder supports only DATA_BYTE_WIDTH == 4");
    end
    if (CODES_COUNT != sata_link_pkg::CODES_COUNT) begin : g_bad_codes
        $error("link_prim_decoder CODES_COUNT must match sata_link_pkg");
    end

    rx_state_e               state_q, state_d;
    logic                    cont_active_q, cont_active_d;
    logic [3:0]              last_code_q, last_code_d;
    logic                    last_valid_q, last_valid_d;
    logic [31:0]             h0_q, h0_d, h1_q, h1_d;
    logic                    h0_valid_q, h0_valid_d, h1_valid_q, h1_valid_d;
    logic [31:0]             crc_q, crc_d;

    logic                    dword_val_q, dword_val_d;
    logic [CODES_COUNT-1:0]  rcvd_dword_q, rcvd_dword_d;
    logic                    dec_err_q, dec_err_d;
    logic [31:0]             data_out_q, data_out_d;
    logic                    data_val_q, data_val_d;
    logic                    data_last_q, data_last_d;
    logic                    crc_good_q, crc_good_d;
    logic                    crc_bad_q, crc_bad_d;

    dword_kind_e             kind;
    logic [3:0]              prim_idx;
    logic                    scr_load, scr_adv;
    logic [31:0]             keystream;
    logic [31:0]             descr;
    logic [31:0]             crc_with_h1;
    logic [31:0]             crc_ref;

    link_descrambler u_descrambler (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (scr_load),
        .advance   (scr_adv),
        .keystream (keystream)
    );

    assign descr       = bus.phy_data ^ keystream;
    assign crc_with_h1 = crc_next(crc_q, h1_q);

    // Primitives are exactly one K-char in byte 0 (K28.3 or K28.5).
    always_comb begin
        kind     = KIND_ERR;
        prim_idx = CODE_DATA;
        if (bus.phy_err) begin
            kind = KIND_ERR;
        end else if (bus.phy_isk == 4'b0000) begin
            kind = KIND_DATA;
        end else if (bus.phy_isk == 4'b0001 &&
                     (bus.phy_data[7:0] == 8'h7C || bus.phy_data[7:0] == 8'hBC)) begin
            kind = KIND_PRIM;
            case (bus.phy_data)
                PRIM_ALIGN: kind = KIND_ALIGN;
                PRIM_CONT:  kind = KIND_CONT;
                PRIM_SYNC:  prim_idx = CODE_SYNC;
                PRIM_X_RDY: prim_idx = CODE_X_RDY;
                PRIM_R_RDY: prim_idx = CODE_R_RDY;
                PRIM_SOF:   prim_idx = CODE_SOF;
                PRIM_EOF:   prim_idx = CODE_EOF;
                PRIM_HOLD:  prim_idx = CODE_HOLD;
                PRIM_HOLDA: prim_idx = CODE_HOLDA;
                PRIM_R_IP:  prim_idx = CODE_R_IP;
                PRIM_R_OK:  prim_idx = CODE_R_OK;
                PRIM_R_ERR: prim_idx = CODE_R_ERR;
                PRIM_WTRM:  prim_idx = CODE_WTRM;
                PRIM_DMAT:  prim_idx = CODE_DMAT;
                default:    kind = KIND_ERR;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        cont_active_d = cont_active_q;
        last_code_d   = last_code_q;
        last_valid_d  = last_valid_q;
        h0_d          = h0_q;
        h1_d          = h1_q;
        h0_valid_d    = h0_valid_q;
        h1_valid_d    = h1_valid_q;
        crc_d         = crc_q;
        dword_val_d   = 1'b0;
        rcvd_dword_d  = '0;
        dec_err_d     = 1'b0;
        data_out_d    = '0;
        data_val_d    = 1'b0;
        data_last_d   = 1'b0;
        crc_good_d    = 1'b0;
        crc_bad_d     = 1'b0;
        scr_load      = 1'b0;
        scr_adv       = 1'b0;
        crc_ref       = h1_valid_q ? crc_with_h1 : crc_q;

        if (!bus.phy_ready) begin
            cont_active_d = 1'b0;
            if (state_q == RX_FRAME) begin
                state_d    = RX_IDLE;
                crc_bad_d  = 1'b1;
                h0_valid_d = 1'b0;
                h1_valid_d = 1'b0;
            end
        end else begin
            case (kind)
                KIND_ERR: begin
                    dword_val_d = 1'b1;
                    dec_err_d   = 1'b1;
                end
                KIND_ALIGN: begin
                end
                KIND_CONT: begin
                    cont_active_d = 1'b1;
                end
                KIND_DATA: begin
                    if (cont_active_q) begin
                        // Repetition junk: re-report the held primitive, leave the scrambler alone.
                        if (last_valid_q) begin
                            dword_val_d  = 1'b1;
                            rcvd_dword_d = code_onehot(last_code_q);
                        end
                    end else begin
                        dword_val_d  = 1'b1;
                        rcvd_dword_d = code_onehot(CODE_DATA);
                        if (state_q == RX_FRAME) begin
                            scr_adv    = 1'b1;
                            h0_d       = descr;
                            h0_valid_d = 1'b1;
                            h1_d       = h0_q;
                            h1_valid_d = h0_valid_q;
                            if (h1_valid_q) begin
                                data_out_d = h1_q;
                                data_val_d = 1'b1;
                                crc_d      = crc_with_h1;
                            end
                        end
                    end
                end
                default: begin
                    dword_val_d   = 1'b1;
                    rcvd_dword_d  = code_onehot(prim_idx);
                    cont_active_d = 1'b0;
                    last_code_d   = prim_idx;
                    last_valid_d  = 1'b1;
                    if (prim_idx == CODE_SOF) begin
                        state_d    = RX_FRAME;
                        scr_load   = 1'b1;
                        crc_d      = CRC_SEED;
                        h0_valid_d = 1'b0;
                        h1_valid_d = 1'b0;
                    end else if (prim_idx == CODE_EOF && state_q == RX_FRAME) begin
                        // h0 holds the received CRC; h1, if present, is the final payload dword.
                        state_d    = RX_IDLE;
                        h0_valid_d = 1'b0;
                        h1_valid_d = 1'b0;
                        if (h1_valid_q) begin
                            data_out_d  = h1_q;
                            data_val_d  = 1'b1;
                            data_last_d = 1'b1;
                        end
                        if (h0_valid_q && h0_q == crc_ref) begin
                            crc_good_d = 1'b1;
                        end else begin
                            crc_bad_d = 1'b1;
                        end
                    end else if (prim_idx == CODE_SYNC && state_q == RX_FRAME) begin
                        state_d    = RX_IDLE;
                        crc_bad_d  = 1'b1;
                        h0_valid_d = 1'b0;
                        h1_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RX_IDLE;
            cont_active_q <= 1'b0;
            last_code_q   <= CODE_DATA;
            last_valid_q  <= 1'b0;
            h0_q          <= '0;
            h1_q          <= '0;
            h0_valid_q    <= 1'b0;
            h1_valid_q    <= 1'b0;
            crc_q         <= CRC_SEED;
            dword_val_q   <= 1'b0;
            rcvd_dword_q  <= '0;
            dec_err_q     <= 1'b0;
            data_out_q    <= '0;
            data_val_q    <= 1'b0;
            data_last_q   <= 1'b0;
            crc_good_q    <= 1'b0;
            crc_bad_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cont_active_q <= cont_active_d;
            last_code_q   <= last_code_d;
            last_valid_q  <= last_valid_d;
            h0_q          <= h0_d;
            h1_q          <= h1_d;
            h0_valid_q    <= h0_valid_d;
            h1_valid_q    <= h1_valid_d;
            crc_q         <= crc_d;
            dword_val_q   <= dword_val_d;
            rcvd_dword_q  <= rcvd_dword_d;
            dec_err_q     <= dec_err_d;
            data_out_q    <= data_out_d;
            data_val_q    <= data_val_d;
            data_last_q   <= data_last_d;
            crc_good_q    <= crc_good_d;
            crc_bad_q     <= crc_bad_d;
        end
    end

    assign bus.dword_val     = dword_val_q;
    assign bus.rcvd_dword    = rcvd_dword_q;
    assign bus.dec_err       = dec_err_q;
    assign bus.data_out      = data_out_q;
    assign bus.data_val_out  = data_val_q;
    assign bus.data_last_out = data_last_q;
    assign bus.crc_good      = crc_good_q;
    assign bus.crc_bad       = crc_bad_q;

    assign dbg = '{state_q, cont_active_q, h0_valid_q, h1_valid_q};

endmodule

// File: tb/tb_link_prim_decoder.sv
// Bench for link_prim_decoder: classification table, directed frame/CONT/abort/reset
// sequences and a randomized stream, all checked against a frame-level reference model.
module tb_link_prim_decoder;

    localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] P_CONT  = 32'h9999AA7C;
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_X_RDY = 32'h5757B57C;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] CRC_INIT = 32'h52325032;

    typedef struct packed {
        logic        dv;
        logic [12:0] rc;
        logic        de;
        logic [31:0] dout;
        logic        dval;
        logic        dlast;
        logic        good;
        logic        bad;
    } out_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  isk;
        logic        err;
        logic        exp_dv;
        logic [12:0] exp_rc;
        logic        exp_de;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    link_prim_decoder_if bus ();
    sata_link_pkg::rx_dbg_t dbg;

    link_prim_decoder #(.DATA_BYTE_WIDTH(4), .CODES_COUNT(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .dbg   (dbg)
    );

    int checks = 0;
    int failures = 0;
    int t_good, t_bad, t_dval, t_last, t_xrdy, t_decerr;

    // Reference model state, frame level.
    logic [31:0] code_word [13];
    bit          m_in_frame;
    bit          m_cont;
    int          m_last;
    logic [31:0] m_frame[$];
    bit          m_bits[$];
    logic [15:0] scr_seed = 16'hF0F6;
    logic [31:0] ks_tab [64];
    logic [31:0] pay [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scrambler as bit recurrence b[t+16] = b[t]^b[t+1]^b[t+3]^b[t+12], b[k]=seed[15-k].
    function automatic void reseed();
        m_bits.delete();
        for (int k = 0; k < 16; k++) m_bits.push_back(scr_seed[15-k]);
    endfunction

    function automatic logic [31:0] ks_next();
        logic [31:0] w;
        bit nb;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            nb = m_bits[0] ^ m_bits[1] ^ m_bits[3] ^ m_bits[12];
            m_bits.push_back(nb);
            w[i] = m_bits.pop_front();
        end
        return w;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] crc, input logic [31:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    function automatic void mdl_reset();
        m_in_frame = 0;
        m_cont = 0;
        m_last = -1;
        m_frame.delete();
        reseed();
    endfunction

    function automatic out_t mdl_step(input logic r, input logic [31:0] d, input logic [3:0] k, input logic e);
        out_t o;
        int code;
        int n;
        logic [31:0] c;
        o = '0;
        code = -1;
        if (!r) begin
            m_cont = 0;
            if (m_in_frame) begin
                o.bad = 1;
                m_in_frame = 0;
                m_frame.delete();
            end
            return o;
        end
        if (!e && k == 4'h0) code = 0;
        else if (!e && k == 4'h1 && (d[7:0] == 8'h7C || d[7:0] == 8'hBC)) begin
            if (d == P_ALIGN) return o;
            if (d == P_CONT) begin
                m_cont = 1;
                return o;
            end
            for (int i = 1; i < 13; i++) if (code_word[i] == d) code = i;
        end
        if (code < 0) begin
            o.dv = 1;
            o.de = 1;
            return o;
        end
        if (code == 0) begin
            if (m_cont) begin
                if (m_last >= 0) begin
                    o.dv = 1;
                    o.rc = 13'd1 << m_last;
                end
                return o;
            end
            o.dv = 1;
            o.rc = 13'd1;
            if (m_in_frame) begin
                m_frame.push_back(d ^ ks_next());
                n = m_frame.size();
                if (n >= 3) begin
                    o.dout = m_frame[n-3];
                    o.dval = 1;
                end
            end
            return o;
        end
        o.dv = 1;
        o.rc = 13'd1 << code;
        m_cont = 0;
        m_last = code;
        if (code == 7) begin
            m_in_frame = 1;
            m_frame.delete();
            reseed();
        end else if (code == 8 && m_in_frame) begin
            n = m_frame.size();
            if (n >= 2) begin
                o.dout = m_frame[n-2];
                o.dval = 1;
                o.dlast = 1;
            end
            if (n == 0) o.bad = 1;
            else begin
                c = CRC_INIT;
                for (int i = 0; i < n - 1; i++) c = crc_word(c, m_frame[i]);
                if (c == m_frame[n-1]) o.good = 1;
                else o.bad = 1;
            end
            m_in_frame = 0;
            m_frame.delete();
        end else if (code == 2 && m_in_frame) begin
            o.bad = 1;
            m_in_frame = 0;
            m_frame.delete();
        end
        return o;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.dv    = bus.dword_val;
        a.rc    = bus.rcvd_dword;
        a.de    = bus.dec_err;
        a.dout  = bus.data_out;
        a.dval  = bus.data_val_out;
        a.dlast = bus.data_last_out;
        a.good  = bus.crc_good;
        a.bad   = bus.crc_bad;
        return a;
    endfunction

    task automatic clr_tally();
        t_good = 0; t_bad = 0; t_dval = 0; t_last = 0; t_xrdy = 0; t_decerr = 0;
    endtask

    task automatic send(input logic r, input logic [31:0] d, input logic [3:0] k, input logic e, output out_t act);
        out_t exp;
        @(negedge clk);
        bus.phy_ready = r;
        bus.phy_data  = d;
        bus.phy_isk   = k;
        bus.phy_err   = e;
        exp = mdl_step(r, d, k, e);
        @(posedge clk);
        #1;
        act = sample();
        check("cycle_outputs", 64'(act), 64'(exp));
        t_good   += int'(act.good);
        t_bad    += int'(act.bad);
        t_dval   += int'(act.dval);
        t_last   += int'(act.dlast);
        t_xrdy   += int'(act.rc[6]);
        t_decerr += int'(act.de);
    endtask

    task automatic tx(input logic r, input logic [31:0] d, input logic [3:0] k, input logic e);
        out_t a;
        send(r, d, k, e, a);
    endtask

    task automatic send_frame(input int n, input bit corrupt, input bit with_align);
        logic [31:0] c;
        c = CRC_INIT;
        tx(1, P_SOF, 4'h1, 0);
        for (int i = 0; i < n; i++) begin
            tx(1, pay[i] ^ ks_tab[i], 4'h0, 0);
            c = crc_word(c, pay[i]);
            if (with_align && i == 0) tx(1, P_ALIGN, 4'h1, 0);
        end
        if (corrupt) c[0] = ~c[0];
        tx(1, c ^ ks_tab[n], 4'h0, 0);
        tx(1, P_EOF, 4'h1, 0);
    endtask

    vec_t vt [15];

    initial begin
        out_t a;
        code_word[0]  = 32'h0;
        code_word[1]  = 32'hD5D5AA7C;
        code_word[2]  = P_SYNC;
        code_word[3]  = 32'h3636B57C;
        code_word[4]  = 32'h3535B57C;
        code_word[5]  = 32'h5656B57C;
        code_word[6]  = P_X_RDY;
        code_word[7]  = P_SOF;
        code_word[8]  = P_EOF;
        code_word[9]  = 32'h9595AA7C;
        code_word[10] = 32'h4A4A957C;
        code_word[11] = 32'h5555B57C;
        code_word[12] = 32'h5858B57C;

        reseed();
        for (int i = 0; i < 64; i++) ks_tab[i] = ks_next();
        mdl_reset();
        clr_tally();

        vt[0]  = '{P_SYNC,         4'h1, 1'b0, 1'b1, 13'h0004, 1'b0};
        vt[1]  = '{P_X_RDY,        4'h1, 1'b0, 1'b1, 13'h0040, 1'b0};
        vt[2]  = '{32'h4A4A957C,   4'h1, 1'b0, 1'b1, 13'h0400, 1'b0};
        vt[3]  = '{32'hD5D5AA7C,   4'h1, 1'b0, 1'b1, 13'h0002, 1'b0};
        vt[4]  = '{32'h9595AA7C,   4'h1, 1'b0, 1'b1, 13'h0200, 1'b0};
        vt[5]  = '{32'h5555B57C,   4'h1, 1'b0, 1'b1, 13'h0800, 1'b0};
        vt[6]  = '{32'h3535B57C,   4'h1, 1'b0, 1'b1, 13'h0010, 1'b0};
        vt[7]  = '{32'h5656B57C,   4'h1, 1'b0, 1'b1, 13'h0020, 1'b0};
        vt[8]  = '{32'h5858B57C,   4'h1, 1'b0, 1'b1, 13'h1000, 1'b0};
        vt[9]  = '{32'h3636B57C,   4'h1, 1'b0, 1'b1, 13'h0008, 1'b0};
        vt[10] = '{P_EOF,          4'h1, 1'b0, 1'b1, 13'h0100, 1'b0};
        vt[11] = '{P_ALIGN,        4'h1, 1'b0, 1'b0, 13'h0000, 1'b0};
        vt[12] = '{32'h1234567C,   4'h1, 1'b0, 1'b1, 13'h0000, 1'b1};
        vt[13] = '{32'hCAFEF00D,   4'h0, 1'b0, 1'b1, 13'h0001, 1'b0};
        vt[14] = '{P_SOF,          4'h1, 1'b0, 1'b1, 13'h0080, 1'b0};

        bus.phy_ready = 0;
        bus.phy_data  = '0;
        bus.phy_isk   = '0;
        bus.phy_err   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(sample()), 64'(0));
        @(negedge clk);
        rst_n = 1;

        // Classification table.
        for (int i = 0; i < 15; i++) begin
            send(1, vt[i].data, vt[i].isk, vt[i].err, a);
            check("table_vector", {32'(i), 15'(0), a.dv, a.rc, a.de}, {32'(i), 15'(0), vt[i].exp_dv, vt[i].exp_rc, vt[i].exp_de});
        end
        tx(1, P_EOF, 4'h1, 0);

        // Good 3-dword frame.
        pay[0] = 32'd1; pay[1] = 32'd2; pay[2] = 32'd3;
        clr_tally();
        send_frame(3, 0, 0);
        check("good_frame_pulses", {32'(t_good), 32'(t_bad)}, {32'd1, 32'd0});
        check("good_frame_data", {32'(t_dval), 32'(t_last)}, {32'd3, 32'd1});

        // Same frame, CRC bit 0 flipped.
        clr_tally();
        send_frame(3, 1, 0);
        check("bad_crc_pulses", {32'(t_good), 32'(t_bad)}, {32'd0, 32'd1});
        check("bad_crc_data", 64'(t_dval), 64'd3);

        // CONT expansion with an ALIGN inside.
        clr_tally();
        tx(1, P_X_RDY, 4'h1, 0);
        tx(1, P_CONT, 4'h1, 0);
        repeat (5) tx(1, $urandom, 4'h0, 0);
        tx(1, P_ALIGN, 4'h1, 0);
        repeat (2) tx(1, $urandom, 4'h0, 0);
        tx(1, P_SOF, 4'h1, 0);
        check("cont_x_rdy_count", 64'(t_xrdy), 64'd8);
        check("cont_no_payload", 64'(t_dval), 64'd0);
        tx(1, P_EOF, 4'h1, 0);

        // SYNC abort, then a clean frame.
        clr_tally();
        tx(1, P_SOF, 4'h1, 0);
        repeat (2) tx(1, $urandom, 4'h0, 0);
        tx(1, P_SYNC, 4'h1, 0);
        check("sync_abort", {32'(t_dval), 32'(t_bad)}, {32'd0, 32'd1});
        clr_tally();
        pay[0] = 32'hDEADBEEF; pay[1] = 32'h01234567;
        send_frame(2, 0, 1);
        check("frame_after_abort", {32'(t_good), 32'(t_bad)}, {32'd1, 32'd0});

        // Zero-payload frame, empty frame, phy_ready drop inside frame.
        clr_tally();
        send_frame(0, 0, 0);
        check("zero_payload_good", {32'(t_good), 32'(t_last)}, {32'd1, 32'd0});
        clr_tally();
        tx(1, P_SOF, 4'h1, 0);
        tx(1, P_EOF, 4'h1, 0);
        tx(1, P_SOF, 4'h1, 0);
        tx(1, $urandom, 4'h0, 0);
        tx(0, $urandom, 4'h0, 0);
        tx(0, $urandom, 4'h0, 0);
        check("empty_and_drop_bad", {32'(t_good), 32'(t_bad)}, {32'd0, 32'd2});

        // Illegal isk and phy_err.
        clr_tally();
        send(1, 32'h12345678, 4'b0010, 0, a);
        check("isk_err_dword", {32'(a.rc), 31'(0), a.de}, {32'd0, 31'(0), 1'b1});
        send(1, 32'h00000055, 4'b0000, 1, a);
        check("phy_err_dword", {32'(a.rc), 31'(0), a.de}, {32'd0, 31'(0), 1'b1});

        // Asynchronous reset mid-frame.
        pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33;
        tx(1, P_SOF, 4'h1, 0);
        for (int i = 0; i < 3; i++) tx(1, pay[i] ^ ks_tab[i], 4'h0, 0);
        #2;
        rst_n = 0;
        bus.phy_ready = 0;
        #1;
        check("async_reset_outputs", 64'(sample()), 64'(0));
        mdl_reset();
        @(negedge clk);
        rst_n = 1;
        clr_tally();
        tx(1, P_EOF, 4'h1, 0);
        check("post_reset_eof", {32'(t_good), 32'(t_bad)}, {32'd0, 32'd0});

        // Randomized stream.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    for (int i = 0; i < 6; i++) pay[i] = $urandom;
                    send_frame($urandom_range(0, 5), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
                end
                2: tx(1, code_word[$urandom_range(1, 12)], 4'h1, 0);
                3: tx(1, P_ALIGN, 4'h1, 0);
                4: begin
                    tx(1, P_CONT, 4'h1, 0);
                    repeat ($urandom_range(1, 4)) tx(1, $urandom, 4'h0, 0);
                end
                5: tx(1, $urandom, 4'h0, 0);
                6: tx(1, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
                7: repeat ($urandom_range(1, 3)) tx(0, $urandom, 4'h0, 0);
                8: begin
                    tx(1, P_SOF, 4'h1, 0);
                    repeat ($urandom_range(0, 3)) tx(1, $urandom, 4'h0, 0);
                    tx(1, P_SYNC, 4'h1, 0);
                end
                default: tx(1, {$urandom_range(0, 65535), 8'($urandom), 8'h7C}, 4'h1, 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
